// File: rtl/scan_chain_ctrl.sv
// -----------------------------------------------------------------------------
// scan_chain_ctrl
//
// Drives one N-bit serial scan chain from a parallel command/response pair.
//   SHIFT (cmd_op=0): shifts cmd_wdata into the chain MSB first while capturing
//                     the old chain contents, which are returned on resp_rdata.
//   RESET (cmd_op=1): holds chain_scan_rstb low for RST_CYCLES cycles so the
//                     chain reloads RST_VAL; resp_rdata returns RST_VAL.
// Runs on the chain's own clock.
//
// Parameters
//   N           chain length in bits (>= 2)
//   RST_VAL     chain contents after a chain reset (driven on chain_rst_din)
//   RST_CYCLES  cycles chain_scan_rstb is held low for a RESET op (>= 1)
//
// Ports
//   scan_clk, scan_rst          clock, async active-high reset
//   cmd_valid/cmd_ready         command handshake (cmd_op, cmd_wdata)
//   resp_valid/resp_ready       response handshake (resp_rdata)
//   busy                        high whenever an operation is in progress
//   chain_scan_en/scan_in       serial load controls towards the chain
//   chain_scan_out              serial data back from the chain (registered
//                               in the chain, one cycle behind)
//   chain_scan_rstb             active-low chain reset
//   chain_rst_din               constant RST_VAL for the chain reset load
//   resp_mismatch               only with SCAN_CHAIN_CTRL_VERIFY_EN defined:
//                               a SHIFT read back something other than what
//                               the controller last wrote
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload steady until that edge;
// resp_valid, once raised, stays up with a stable resp_rdata until accepted.
// cmd_ready is high only while idle, so commands never overlap.
//
// Optional feature macro: SCAN_CHAIN_CTRL_VERIFY_EN
// -----------------------------------------------------------------------------
module scan_chain_ctrl #(
   parameter int unsigned    N          = 32,
   parameter logic [N-1:0]   RST_VAL    = '0,
   parameter int unsigned    RST_CYCLES = 2
) (
   input  logic         scan_clk,
   input  logic         scan_rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_op,
   input  logic [N-1:0] cmd_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [N-1:0] resp_rdata,
   output logic         busy,
   output logic         chain_scan_en,
   output logic         chain_scan_in,
   input  logic         chain_scan_out,
   output logic         chain_scan_rstb,
   output logic [N-1:0] chain_rst_din
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
   ,
   output logic         resp_mismatch
`endif
);

   // One counter serves both the shift phase (0..N-1) and the reset pulse
   // (0..RST_CYCLES-1); it is sized for whichever needs more bits.
   localparam int unsigned SCW = $clog2(N + 1);
   localparam int unsigned RCW = $clog2(RST_CYCLES + 1);
   localparam int unsigned CW  = (SCW > RCW) ? SCW : RCW;

   localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_CAPT  = 3'd2,
      ST_RST   = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   // Bits of the command word still to be shifted out, next bit at the top.
   logic [N-2:0]   sh_q, sh_d;
   // Capture history: the newest sample is appended below these bits, so the
   // final sample (old bit 0) completes the word without another register.
   logic [N-2:0]   cap_q, cap_d;
   logic [N-1:0]   cap_shift;
   logic           cmd_ready_q, cmd_ready_d;
   logic           resp_valid_q, resp_valid_d;
   logic [N-1:0]   resp_rdata_q, resp_rdata_d;
   logic           busy_q, busy_d;
   logic           scan_en_q, scan_en_d;
   logic           scan_in_q, scan_in_d;
   logic           rstb_q, rstb_d;

`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
   // What the chain should hold if nothing but this controller touched it.
   logic [N-1:0]   shadow_q, shadow_d;
   logic [N-1:0]   wdata_q, wdata_d;
   logic           mismatch_q, mismatch_d;
`endif

   assign cap_shift = {cap_q, chain_scan_out};

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sh_d         = sh_q;
      cap_d        = cap_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      // The chain is left quiet unless a state below asks otherwise.
      scan_en_d    = 1'b0;
      scan_in_d    = 1'b0;
      rstb_d       = 1'b1;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
      shadow_d     = shadow_q;
      wdata_d      = wdata_q;
      mismatch_d   = mismatch_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cnt_d = '0;
               if (cmd_op) begin
                  state_d = ST_RST;
                  rstb_d  = 1'b0;
               end else begin
                  state_d   = ST_SHIFT;
                  scan_en_d = 1'b1;
                  scan_in_d = cmd_wdata[N-1];
                  sh_d      = cmd_wdata[N-2:0];
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
                  wdata_d   = cmd_wdata;
`endif
               end
            end
         end

         ST_SHIFT: begin
            // The chain's output register lags by one cycle, so the first
            // shift cycle still shows a stale bit and is not sampled.
            if (cnt_q != '0) begin
               cap_d = cap_shift[N-2:0];
            end
            if (cnt_q == SHIFT_LAST) begin
               state_d = ST_CAPT;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               scan_en_d = 1'b1;
               scan_in_d = sh_q[N-2];
               sh_d      = sh_q << 1;
            end
         end

         ST_CAPT: begin
            // Last sample (old bit 0) arrives here with the chain already idle.
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = cap_shift;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
            mismatch_d   = (cap_shift != shadow_q);
            shadow_d     = wdata_q;
`endif
         end

         ST_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d      = ST_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = RST_VAL;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
               mismatch_d   = 1'b0;
               shadow_d     = RST_VAL;
`endif
            end else begin
               cnt_d  = cnt_q + 1'b1;
               rstb_d = 1'b0;
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
               mismatch_d   = 1'b0;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered status follows the state being entered.
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge scan_clk or posedge scan_rst) begin
      if (scan_rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sh_q         <= '0;
         cap_q        <= '0;
         cmd_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         busy_q       <= 1'b0;
         scan_en_q    <= 1'b0;
         scan_in_q    <= 1'b0;
         // Holding rstb low during controller reset also resets the chain.
         rstb_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_q         <= sh_d;
         cap_q        <= cap_d;
         cmd_ready_q  <= cmd_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         busy_q       <= busy_d;
         scan_en_q    <= scan_en_d;
         scan_in_q    <= scan_in_d;
         rstb_q       <= rstb_d;
      end
   end

`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
   always_ff @(posedge scan_clk or posedge scan_rst) begin
      if (scan_rst) begin
         shadow_q   <= RST_VAL;
         wdata_q    <= '0;
         mismatch_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         wdata_q    <= wdata_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign resp_mismatch = mismatch_q;
`endif

   assign cmd_ready       = cmd_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = resp_rdata_q;
   assign busy            = busy_q;
   assign chain_scan_en   = scan_en_q;
   assign chain_scan_in   = scan_in_q;
   assign chain_scan_rstb = rstb_q;
   assign chain_rst_din   = RST_VAL;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;

   localparam int unsigned  N  = 8;
   localparam logic [N-1:0] RV = 8'hA5;
   localparam int unsigned  RC = 2;

   logic         clk;
   logic         scan_rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic         cmd_op;
   logic [N-1:0] cmd_wdata;
   logic         resp_valid;
   logic         resp_ready;
   logic [N-1:0] resp_rdata;
   logic         busy;
   logic         chain_scan_en;
   logic         chain_scan_in;
   logic         chain_scan_out;
   logic         chain_scan_rstb;
   logic [N-1:0] chain_rst_din;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
   logic         resp_mismatch;
`endif

   int total = 0;
   int bad   = 0;

   // ---------------------------------------------------------------- DUT
   scan_chain_ctrl #(.N(N), .RST_VAL(RV), .RST_CYCLES(RC)) dut (
      .scan_clk        (clk),
      .scan_rst        (scan_rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_wdata       (cmd_wdata),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_rdata      (resp_rdata),
      .busy            (busy),
      .chain_scan_en   (chain_scan_en),
      .chain_scan_in   (chain_scan_in),
      .chain_scan_out  (chain_scan_out),
      .chain_scan_rstb (chain_scan_rstb),
      .chain_rst_din   (chain_rst_din)
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
      ,
      .resp_mismatch   (resp_mismatch)
`endif
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- chain
   // Simple scan chain: shifts on scan_en, output bit registered every edge,
   // async reset from rstb. flip_mask lets the bench corrupt its contents.
   logic [N-1:0] chain;
   logic         so_q;
   logic [N-1:0] flip_mask;

   always @(posedge clk or negedge chain_scan_rstb) begin
      if (!chain_scan_rstb) begin
         chain <= chain_rst_din;
         so_q  <= chain_rst_din[N-1];
      end else begin
         chain <= (chain_scan_en ? {chain[N-2:0], chain_scan_in} : chain) ^ flip_mask;
         so_q  <= chain[N-1];
      end
   end
   assign chain_scan_out = so_q;

   // ---------------------------------------------------------------- model
   // Transaction-level view: an op accepted at edge count m_e makes the
   // following cycle "k=1"; every expected output is a rule over k.
   int           ec = 0;
   int           rel_edges = 0;
   logic         m_active = 1'b0;
   logic         m_op = 1'b0;
   int           m_e = 0;
   logic [N-1:0] m_wdata = '0;
   logic [N-1:0] m_rdata = '0;
   logic         m_mm = 1'b0;
   logic [N-1:0] m_content = RV;
   logic [N-1:0] m_shadow = RV;
   logic         m_acc, m_hs;

   function automatic int k_now();
      return ec - m_e + 1;
   endfunction

   function automatic logic e_cmd_ready();
      return !m_active && (rel_edges >= 1);
   endfunction

   function automatic logic e_scan_en();
      return m_active && !m_op && (k_now() <= int'(N));
   endfunction

   function automatic logic e_rstb();
      return (rel_edges >= 1) && !(m_active && m_op && (k_now() <= int'(RC)));
   endfunction

   function automatic logic e_resp_valid();
      if (!m_active) return 1'b0;
      return m_op ? (k_now() >= int'(RC) + 1) : (k_now() >= int'(N) + 2);
   endfunction

   always @(posedge clk) begin
      if (scan_rst) begin
         m_active  = 1'b0;
         rel_edges = 0;
         m_content = RV;
         m_shadow  = RV;
      end else begin
         m_acc = e_cmd_ready() && cmd_valid;
         m_hs  = e_resp_valid() && resp_ready;
         ec++;
         if (rel_edges < 2) rel_edges++;
         if (m_hs) m_active = 1'b0;
         if (m_acc) begin
            m_active = 1'b1;
            m_op     = cmd_op;
            m_e      = ec;
            m_wdata  = cmd_wdata;
            if (cmd_op) begin
               m_rdata   = RV;
               m_mm      = 1'b0;
               m_content = RV;
               m_shadow  = RV;
            end else begin
               m_rdata   = m_content;
               m_mm      = (m_content != m_shadow);
               m_content = cmd_wdata;
               m_shadow  = cmd_wdata;
            end
         end
         m_content = m_content ^ flip_mask;
      end
   end

   // ---------------------------------------------------------------- compare
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int           en_cnt = 0;
   logic [N-1:0] sin_hist = '0;
   int           rstb_lo = 0;

   always @(negedge clk) begin
      if (scan_rst) begin
         chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
         chk("rst_busy", {31'd0, busy}, 0);
         chk("rst_scan_en", {31'd0, chain_scan_en}, 0);
         chk("rst_scan_in", {31'd0, chain_scan_in}, 0);
         chk("rst_rstb", {31'd0, chain_scan_rstb}, 0);
         chk("rst_resp_valid", {31'd0, resp_valid}, 0);
         chk("rst_rdata", {24'd0, resp_rdata}, 0);
      end else begin
         chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_cmd_ready()});
         chk("busy", {31'd0, busy}, {31'd0, m_active});
         chk("scan_en", {31'd0, chain_scan_en}, {31'd0, e_scan_en()});
         if (e_scan_en())
            chk("scan_in", {31'd0, chain_scan_in}, {31'd0, m_wdata[N - k_now()]});
         chk("rstb", {31'd0, chain_scan_rstb}, {31'd0, e_rstb()});
         chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_resp_valid()});
         if (e_resp_valid())
            chk("rdata", {24'd0, resp_rdata}, {24'd0, m_rdata});
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
         chk("mismatch", {31'd0, resp_mismatch}, {31'd0, e_resp_valid() && m_mm});
`endif
         if (rel_edges >= 1 && !chain_scan_rstb) rstb_lo++;
      end
      chk("rst_din", {24'd0, chain_rst_din}, {24'd0, RV});
      if (chain_scan_en) begin
         en_cnt++;
         sin_hist = {sin_hist[N-2:0], chain_scan_in};
      end
   end

   // ---------------------------------------------------------------- driver
   logic [N-1:0] last_rd;
   int           last_lat;
   logic         last_mm;

   // Called just after a rising edge; returns just after the response edge.
   task automatic do_cmd(input logic op, input logic [N-1:0] wd, input int hold);
      int guard;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wdata = wd;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", 0, 1);
         cmd_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_wdata = N'($urandom);
      last_lat = 0;
      do begin
         @(negedge clk);
         last_lat++;
      end while (!resp_valid && last_lat < 200);
      if (!resp_valid) begin
         chk("resp_timeout", 0, 1);
         @(posedge clk); #1;
         return;
      end
      last_rd = resp_rdata;
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
      last_mm = resp_mismatch;
`else
      last_mm = 1'b0;
`endif
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic flip(input logic [N-1:0] m);
      flip_mask = m;
      @(posedge clk); #1;
      flip_mask = '0;
   endtask

   // ---------------------------------------------------------------- stimulus
   int en0, rl0;

   initial begin
      scan_rst   = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 1'b0;
      cmd_wdata  = '0;
      resp_ready = 1'b0;
      flip_mask  = '0;
      last_rd    = '0;
      last_lat   = 0;
      last_mm    = 1'b0;
      repeat (3) @(posedge clk);
      #1 scan_rst = 1'b0;
      @(posedge clk); #1;

      // First SHIFT after reset returns RST_VAL; MSB-first bit order.
      en0 = en_cnt;
      do_cmd(1'b0, 8'h3C, 0);
      chk("t1_rdata", {24'd0, last_rd}, 32'hA5);
      chk("t1_latency", last_lat, 10);
      chk("t1_en_cycles", en_cnt - en0, 8);
      chk("t1_bit_order", {24'd0, sin_hist}, 32'b00111100);

      do_cmd(1'b0, 8'hFF, 0);
      chk("t2_rdata", {24'd0, last_rd}, 32'h3C);

      // RESET op after loading 3C.
      do_cmd(1'b0, 8'h3C, 0);
      chk("t3_rdata_ff", {24'd0, last_rd}, 32'hFF);
      rl0 = rstb_lo;
      do_cmd(1'b1, 8'h00, 0);
      chk("t3_reset_rdata", {24'd0, last_rd}, 32'hA5);
      chk("t3_reset_latency", last_lat, 3);
      chk("t3_rstb_low", rstb_lo - rl0, 2);
      do_cmd(1'b0, 8'h00, 0);
      chk("t3_after_reset", {24'd0, last_rd}, 32'hA5);

      // Long backpressure.
      do_cmd(1'b0, 8'h81, 20);
      chk("t4_rdata_hold", {24'd0, last_rd}, 32'h00);

      // scan_rst in the middle of a SHIFT.
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_wdata = 8'h5A;
      @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 scan_rst = 1'b1;
      @(negedge clk);
      chk("t5_scan_en", {31'd0, chain_scan_en}, 0);
      chk("t5_resp_valid", {31'd0, resp_valid}, 0);
      repeat (2) @(posedge clk);
      #1 scan_rst = 1'b0;
      @(posedge clk); #1;
      do_cmd(1'b0, 8'h00, 0);
      chk("t5_rdata", {24'd0, last_rd}, 32'hA5);

      // Corrupt the chain behind the controller's back.
      do_cmd(1'b0, 8'h3C, 0);
      flip(8'h01);
      do_cmd(1'b0, 8'h00, 0);
      chk("t6_flip_rdata", {24'd0, last_rd}, 32'h3D);
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
      chk("t6_mm_flip", {31'd0, last_mm}, 1);
`endif
      do_cmd(1'b0, 8'h00, 0);
      chk("t6_clean_rdata", {24'd0, last_rd}, 32'h00);
`ifdef SCAN_CHAIN_CTRL_VERIFY_EN
      chk("t6_mm_clean", {31'd0, last_mm}, 0);
`endif

      // Randomized traffic; the per-cycle compare against the model checks it.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         if ($urandom_range(0, 7) == 0) flip(N'($urandom_range(1, 255)));
         do_cmd($urandom_range(0, 3) == 0, N'($urandom), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
